// File: rtl/cpu_pkg.sv
// Shared fetch-stage types and defaults for the FDE CPU.
package cpu_pkg;

    localparam int unsigned CPU_ADDR_W = 12;
    localparam int unsigned CPU_DATA_W = 32;
    localparam logic [CPU_ADDR_W-1:0] CPU_RESET_PC = '0;

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        BUBBLE = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [CPU_DATA_W-1:0] instr;
        logic [CPU_ADDR_W-1:0] pc;
    } fetch_word;

endpackage

// File: rtl/fetch_skid_buf.sv
// Two-entry in-order buffer: output register plus skid, with flush.
module fetch_skid_buf
    import cpu_pkg::*;
#(
    parameter type word_t = fetch_word
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  i_flush,
    input  logic  i_in_vld,
    input  word_t i_in_word,
    input  logic  i_pop,
    output logic  o_out_vld,
    output word_t o_out_word,
    output logic  o_skid_vld
);

    logic  out_vld_q, out_vld_d;
    word_t out_word_q, out_word_d;
    logic  skid_vld_q, skid_vld_d;
    word_t skid_word_q, skid_word_d;

    always_comb begin
        out_vld_d   = out_vld_q;
        out_word_d  = out_word_q;
        skid_vld_d  = skid_vld_q;
        skid_word_d = skid_word_q;
        if (i_flush) begin
            out_vld_d  = 1'b0;
            skid_vld_d = 1'b0;
        end else if (!out_vld_q || i_pop) begin
            // Skid drains first so an arrival never overtakes an older word.
            if (skid_vld_q) begin
                out_vld_d   = 1'b1;
                out_word_d  = skid_word_q;
                skid_vld_d  = i_in_vld;
                skid_word_d = i_in_word;
            end else begin
                out_vld_d  = i_in_vld;
                out_word_d = i_in_vld ? i_in_word : out_word_q;
            end
        end else if (i_in_vld) begin
            skid_vld_d  = 1'b1;
            skid_word_d = i_in_word;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_vld_q   <= 1'b0;
            out_word_q  <= '0;
            skid_vld_q  <= 1'b0;
            skid_word_q <= '0;
        end else begin
            out_vld_q   <= out_vld_d;
            out_word_q  <= out_word_d;
            skid_vld_q  <= skid_vld_d;
            skid_word_q <= skid_word_d;
        end
    end

    assign o_out_vld  = out_vld_q;
    assign o_out_word = out_word_q;
    assign o_skid_vld = skid_vld_q;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC/issue control, redirect bubble, and 2-entry output queue.
// Optional FETCH_PERF_CNT_EN adds fetch and stall counters.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W = CPU_ADDR_W,
    parameter int unsigned DATA_W = CPU_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(CPU_RESET_PC)
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] o_imem_addr,
    input  logic [DATA_W-1:0] i_imem_data,
    input  logic              i_redirect,
    input  logic [ADDR_W-1:0] i_redirect_pc,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_instr,
    output logic [ADDR_W-1:0] o_pc
`ifdef FETCH_PERF_CNT_EN
   ,output logic [31:0]       o_fetch_cnt,
    output logic [31:0]       o_stall_cnt
`endif
);

    typedef struct packed {
        logic [DATA_W-1:0] instr;
        logic [ADDR_W-1:0] pc;
    } word_t;

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic              inflight_vld_q, inflight_vld_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;

    logic       skid_vld;
    logic       pop;
    logic [1:0] occ;
    logic       issue;
    word_t      in_word;
    word_t      out_word;

    assign pop = o_valid & i_ready;
    assign occ = {1'b0, o_valid} + {1'b0, skid_vld} + {1'b0, inflight_vld_q};

    always_comb begin
        state_d        = state_q;
        fetch_pc_d     = fetch_pc_q;
        inflight_vld_d = 1'b0;
        inflight_pc_d  = inflight_pc_q;
        issue          = 1'b0;
        if (i_redirect) begin
            state_d    = BUBBLE;
            fetch_pc_d = i_redirect_pc;
        end else begin
            case (state_q)
                RUN: begin
                    // Issue only if the word can land somewhere once it returns.
                    issue = (occ - {1'b0, pop}) <= 2'd1;
                    if (issue) begin
                        inflight_vld_d = 1'b1;
                        inflight_pc_d  = fetch_pc_q;
                        fetch_pc_d     = fetch_pc_q + 1'b1;
                    end
                end
                BUBBLE:  state_d = RUN;
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= RUN;
            fetch_pc_q     <= RESET_PC;
            inflight_vld_q <= 1'b0;
            inflight_pc_q  <= '0;
        end else begin
            state_q        <= state_d;
            fetch_pc_q     <= fetch_pc_d;
            inflight_vld_q <= inflight_vld_d;
            inflight_pc_q  <= inflight_pc_d;
        end
    end

    assign in_word = '{instr: i_imem_data, pc: inflight_pc_q};

    fetch_skid_buf #(
        .word_t (word_t)
    ) u_skid_buf (
        .clk        (clk),
        .reset      (reset),
        .i_flush    (i_redirect),
        .i_in_vld   (inflight_vld_q),
        .i_in_word  (in_word),
        .i_pop      (pop),
        .o_out_vld  (o_valid),
        .o_out_word (out_word),
        .o_skid_vld (skid_vld)
    );

    assign o_imem_addr = fetch_pc_q;
    assign o_instr     = out_word.instr;
    assign o_pc        = out_word.pc;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q + {31'd0, pop};
        stall_cnt_d = stall_cnt_q + {31'd0, o_valid & ~i_ready};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign o_fetch_cnt = fetch_cnt_q;
    assign o_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a 1-cycle registered memory model.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic [11:0] o_imem_addr;
    logic [31:0] i_imem_data;
    logic        i_redirect;
    logic [11:0] i_redirect_pc;
    logic        i_ready;
    logic        o_valid;
    logic [31:0] o_instr;
    logic [11:0] o_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] o_fetch_cnt;
    logic [31:0] o_stall_cnt;
`endif

    logic [31:0] mem [4096];
    int checks = 0;
    int errors = 0;

    fetch_unit #(
        .ADDR_W   (12),
        .DATA_W   (32),
        .RESET_PC (12'h000)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .o_imem_addr   (o_imem_addr),
        .i_imem_data   (i_imem_data),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .i_ready       (i_ready),
        .o_valid       (o_valid),
        .o_instr       (o_instr),
        .o_pc          (o_pc)
`ifdef FETCH_PERF_CNT_EN
       ,.o_fetch_cnt   (o_fetch_cnt),
        .o_stall_cnt   (o_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) i_imem_data <= mem[o_imem_addr];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++;
        if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", o_valid); end
        checks++;
        if (o_instr !== 32'h0) begin errors++; $display("FAIL reset_instr got %h want 00000000", o_instr); end
        checks++;
        if (o_pc !== 12'h000) begin errors++; $display("FAIL reset_pc got %h want 000", o_pc); end
        checks++;
        if (o_imem_addr !== 12'h000) begin errors++; $display("FAIL reset_addr got %h want 000", o_imem_addr); end
    endtask

    task automatic test_basic();
        logic [31:0] exp_instr [2];
        exp_instr[0] = 32'h0000_1234;
        exp_instr[1] = 32'h0000_5678;
        i_ready = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        step();
        checks++;
        if (o_valid !== 1'b0) begin errors++; $display("FAIL basic_first_edge_valid got %b want 0", o_valid); end
        checks++;
        if (o_imem_addr !== 12'h001) begin errors++; $display("FAIL basic_first_edge_addr got %h want 001", o_imem_addr); end
        for (int k = 0; k < 2; k++) begin
            step();
            checks++;
            if (o_valid !== 1'b1 || o_pc !== 12'(k) || o_instr !== exp_instr[k])
                begin errors++; $display("FAIL basic_word%0d got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h", k, o_valid, o_pc, o_instr, 12'(k), exp_instr[k]); end
            checks++;
            if (o_imem_addr !== 12'(k + 2)) begin errors++; $display("FAIL basic_addr%0d got %h want %h", k, o_imem_addr, 12'(k + 2)); end
        end
    endtask

    task automatic test_backpressure();
        logic [11:0] exp_pc [3];
        logic [31:0] exp_instr [3];
        logic [11:0] exp_addr [3];
        exp_pc[0] = 12'h002; exp_instr[0] = 32'h0000_9ABC; exp_addr[0] = 12'h004;
        exp_pc[1] = 12'h003; exp_instr[1] = 32'hC0DE_0003; exp_addr[1] = 12'h005;
        exp_pc[2] = 12'h004; exp_instr[2] = 32'hC0DE_0004; exp_addr[2] = 12'h006;
        i_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            checks++;
            if (o_valid !== 1'b1 || o_pc !== 12'h001 || o_instr !== 32'h0000_5678)
                begin errors++; $display("FAIL bp_hold%0d got v=%b pc=%h instr=%h want v=1 pc=001 instr=00005678", k, o_valid, o_pc, o_instr); end
            checks++;
            if (o_imem_addr !== 12'h003) begin errors++; $display("FAIL bp_addr%0d got %h want 003", k, o_imem_addr); end
        end
        i_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (o_valid !== 1'b1 || o_pc !== exp_pc[k] || o_instr !== exp_instr[k])
                begin errors++; $display("FAIL bp_release%0d got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h", k, o_valid, o_pc, o_instr, exp_pc[k], exp_instr[k]); end
            checks++;
            if (o_imem_addr !== exp_addr[k]) begin errors++; $display("FAIL bp_release_addr%0d got %h want %h", k, o_imem_addr, exp_addr[k]); end
        end
    endtask

    task automatic test_redirect();
        logic [11:0] exp_addr [3];
        exp_addr[0] = 12'h100; exp_addr[1] = 12'h100; exp_addr[2] = 12'h101;
        i_redirect    = 1'b1;
        i_redirect_pc = 12'h100;
        step();
        i_redirect = 1'b0;
        checks++;
        if (o_valid !== 1'b0) begin errors++; $display("FAIL redir_flush_valid got %b want 0", o_valid); end
        checks++;
        if (o_imem_addr !== exp_addr[0]) begin errors++; $display("FAIL redir_addr0 got %h want %h", o_imem_addr, exp_addr[0]); end
        for (int k = 1; k < 3; k++) begin
            step();
            checks++;
            if (o_valid !== 1'b0) begin errors++; $display("FAIL redir_gap%0d valid got %b want 0", k, o_valid); end
            checks++;
            if (o_imem_addr !== exp_addr[k]) begin errors++; $display("FAIL redir_addr%0d got %h want %h", k, o_imem_addr, exp_addr[k]); end
        end
        step();
        checks++;
        if (o_valid !== 1'b1 || o_pc !== 12'h100 || o_instr !== 32'hC0DE_0100)
            begin errors++; $display("FAIL redir_target got v=%b pc=%h instr=%h want v=1 pc=100 instr=c0de0100", o_valid, o_pc, o_instr); end
        step();
        checks++;
        if (o_valid !== 1'b1 || o_pc !== 12'h101 || o_instr !== 32'hC0DE_0101)
            begin errors++; $display("FAIL redir_next got v=%b pc=%h instr=%h want v=1 pc=101 instr=c0de0101", o_valid, o_pc, o_instr); end
    endtask

    task automatic test_simultaneous();
        // o_valid=1 with a word in flight and i_ready=1: pop and arrival coincide with redirect.
        checks++;
        if (o_valid !== 1'b1 || i_ready !== 1'b1) begin errors++; $display("FAIL simul_precond got v=%b want 1", o_valid); end
        i_redirect    = 1'b1;
        i_redirect_pc = 12'h200;
        step();
        i_redirect = 1'b0;
        checks++;
        if (o_valid !== 1'b0 || o_imem_addr !== 12'h200)
            begin errors++; $display("FAIL simul_flush got v=%b addr=%h want v=0 addr=200", o_valid, o_imem_addr); end
        for (int k = 0; k < 2; k++) begin
            step();
            checks++;
            if (o_valid !== 1'b0) begin errors++; $display("FAIL simul_gap%0d got v=%b pc=%h want v=0", k, o_valid, o_pc); end
        end
        step();
        checks++;
        if (o_valid !== 1'b1 || o_pc !== 12'h200 || o_instr !== 32'hC0DE_0200)
            begin errors++; $display("FAIL simul_target got v=%b pc=%h instr=%h want v=1 pc=200 instr=c0de0200", o_valid, o_pc, o_instr); end
        step();
        checks++;
        if (o_valid !== 1'b1 || o_pc !== 12'h201) begin errors++; $display("FAIL simul_next got v=%b pc=%h want v=1 pc=201", o_valid, o_pc); end
    endtask

    task automatic test_wrap();
        logic [11:0] exp_addr [3];
        logic [11:0] exp_pc [4];
        logic [31:0] exp_instr [4];
        exp_addr[0] = 12'hFFE; exp_addr[1] = 12'hFFE; exp_addr[2] = 12'hFFF;
        exp_pc[0] = 12'hFFE; exp_instr[0] = 32'hC0DE_0FFE;
        exp_pc[1] = 12'hFFF; exp_instr[1] = 32'hC0DE_0FFF;
        exp_pc[2] = 12'h000; exp_instr[2] = 32'h0000_1234;
        exp_pc[3] = 12'h001; exp_instr[3] = 32'h0000_5678;
        i_redirect    = 1'b1;
        i_redirect_pc = 12'h050;
        step();
        checks++;
        if (o_valid !== 1'b0 || o_imem_addr !== 12'h050)
            begin errors++; $display("FAIL wrap_first_redir got v=%b addr=%h want v=0 addr=050", o_valid, o_imem_addr); end
        i_redirect_pc = 12'hFFE;
        for (int k = 0; k < 3; k++) begin
            step();
            i_redirect = 1'b0;
            checks++;
            if (o_valid !== 1'b0 || o_imem_addr !== exp_addr[k])
                begin errors++; $display("FAIL wrap_gap%0d got v=%b addr=%h want v=0 addr=%h", k, o_valid, o_imem_addr, exp_addr[k]); end
        end
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if (o_valid !== 1'b1 || o_pc !== exp_pc[k] || o_instr !== exp_instr[k])
                begin errors++; $display("FAIL wrap_word%0d got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h", k, o_valid, o_pc, o_instr, exp_pc[k], exp_instr[k]); end
        end
    endtask

    task automatic test_async_reset();
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (o_valid !== 1'b0 || o_instr !== 32'h0 || o_pc !== 12'h000 || o_imem_addr !== 12'h000)
            begin errors++; $display("FAIL arst_immediate got v=%b instr=%h pc=%h addr=%h want 0/0/0/0", o_valid, o_instr, o_pc, o_imem_addr); end
        step();
        checks++;
        if (o_valid !== 1'b0 || o_imem_addr !== 12'h000)
            begin errors++; $display("FAIL arst_held got v=%b addr=%h want v=0 addr=000", o_valid, o_imem_addr); end
        @(negedge clk);
        reset = 1'b1;
        step();
        checks++;
        if (o_valid !== 1'b0 || o_imem_addr !== 12'h001)
            begin errors++; $display("FAIL arst_restart_edge1 got v=%b addr=%h want v=0 addr=001", o_valid, o_imem_addr); end
        step();
        checks++;
        if (o_valid !== 1'b1 || o_pc !== 12'h000 || o_instr !== 32'h0000_1234)
            begin errors++; $display("FAIL arst_restart_word0 got v=%b pc=%h instr=%h want v=1 pc=000 instr=00001234", o_valid, o_pc, o_instr); end
        step();
        checks++;
        if (o_valid !== 1'b1 || o_pc !== 12'h001 || o_instr !== 32'h0000_5678)
            begin errors++; $display("FAIL arst_restart_word1 got v=%b pc=%h instr=%h want v=1 pc=001 instr=00005678", o_valid, o_pc, o_instr); end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
        mem[0] = 32'h0000_1234;
        mem[1] = 32'h0000_5678;
        mem[2] = 32'h0000_9ABC;
        reset         = 1'b0;
        i_redirect    = 1'b0;
        i_redirect_pc = '0;
        i_ready       = 1'b0;
        #12;
        test_reset();
        test_basic();
        test_backpressure();
        test_redirect();
        test_simultaneous();
        test_wrap();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
